// File: rtl/sqrt_bcd_converter.sv
// rtl/sqrt_bcd_converter.sv - binary root to packed BCD converter (iterative double dabble)
//
// Captures an unsigned binary root when idle and converts it to packed BCD,
// one bit per clock. The last completed result stays on bcd_o until the next
// conversion finishes.
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_i    in   synchronous active-high reset
//   valid_i  in   root available (sampled only while idle)
//   sqrt_i   in   WIDTH-bit unsigned binary root
//   ready_o  out  idle and accepting a new root (forced low during reset)
//   bcd_o    out  4*DIGITS-bit packed BCD result, digit 0 in bits [3:0]
//   done_o   out  one-cycle pulse when bcd_o has just been updated

module sqrt_bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [WIDTH-1:0]      sqrt_i,
  output logic                  ready_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  done_o
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  function automatic logic [127:0] pow10(input int n);
    logic [127:0] r;
    r = 128'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 128'd10;
    end
    return r;
  endfunction

  localparam logic [127:0] MAX_BIN = (128'd1 << WIDTH) - 128'd1;

  // The largest binary input must fit in DIGITS decimal digits.
  generate
    if (pow10(DIGITS) <= MAX_BIN) begin : g_digits_too_few
      $error("sqrt_bcd_converter: DIGITS too small for WIDTH");
    end
  endgenerate

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [BCD_W-1:0] acc;
  logic [BCD_W-1:0] acc_adj;
  logic [BCD_W-1:0] acc_next;
  logic [WIDTH-1:0] bin;
  logic [CNT_W-1:0] cnt;

  // Add-3 correction per nibble; digits are <= 9 so results stay within 4 bits.
  always_comb begin
    acc_adj = acc;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc[4*k +: 4] >= 4'd5) begin
        acc_adj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
      end
    end
    acc_next = {acc_adj[BCD_W-2:0], bin[WIDTH-1]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      acc   <= '0;
      bin   <= '0;
      cnt   <= '0;
      bcd_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            bin   <= sqrt_i;
            acc   <= '0;
            cnt   <= CNT_W'(WIDTH);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= acc_next;
          bin <= {bin[WIDTH-2:0], 1'b0};
          cnt <= cnt - 1'b1;
          // Last iteration: publish the fully shifted accumulator directly.
          if (cnt == CNT_W'(1)) begin
            bcd_o <= acc_next;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ready_o = !rst_i && (state == IDLE);
  assign done_o  = (state == DONE);

endmodule

// File: tb/tb_sqrt_bcd_converter.sv
// tb/tb_sqrt_bcd_converter.sv - self-checking bench for sqrt_bcd_converter
module tb_sqrt_bcd_converter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [15:0] sqrt = '0;
  logic        ready;
  logic [19:0] bcd;
  logic        done;

  logic        valid8 = 1'b0;
  logic [7:0]  sqrt8 = '0;
  logic        ready8;
  logic [11:0] bcd8;
  logic        done8;

  int checks = 0;
  int errors = 0;
  logic [19:0] last_bcd = '0;
  logic [11:0] last_bcd8 = '0;

  always #5 clk = ~clk;

  sqrt_bcd_converter #(.WIDTH(16), .DIGITS(5)) u_dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .sqrt_i(sqrt),
    .ready_o(ready), .bcd_o(bcd), .done_o(done)
  );

  sqrt_bcd_converter #(.WIDTH(8), .DIGITS(3)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid8), .sqrt_i(sqrt8),
    .ready_o(ready8), .bcd_o(bcd8), .done_o(done8)
  );

  typedef struct {
    logic [15:0] val;
    logic [19:0] exp;
  } vec_t;

  // Decimal digits extracted with plain division, packed 4 bits per digit.
  function automatic logic [31:0] ref_bcd(input int unsigned v, input int digits);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < digits; k++) begin
      r = r | ((v % 10) << (4 * k));
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_conv(input string name, input logic [15:0] v, input logic [19:0] exp);
    int lat, busy, pulses;
    logic [19:0] got;
    sqrt = v;
    valid = 1'b1;
    step();
    valid = 1'b0;
    lat = -1; busy = 0; pulses = 0; got = '0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        pulses++;
        lat = c;
        got = bcd;
      end else if (!ready) begin
        check($sformatf("%s_hold", name), 32'(bcd), 32'(last_bcd));
      end
      if (ready) break;
      busy++;
      step();
    end
    check($sformatf("%s_bcd", name), 32'(got), 32'(exp));
    check($sformatf("%s_latency", name), lat, 16);
    check($sformatf("%s_busy", name), busy, 17);
    check($sformatf("%s_pulses", name), pulses, 1);
    check($sformatf("%s_after", name), 32'(bcd), 32'(exp));
    last_bcd = exp;
  endtask

  task automatic run_conv8(input string name, input logic [7:0] v, input logic [11:0] exp);
    int lat, pulses;
    logic [11:0] got;
    sqrt8 = v;
    valid8 = 1'b1;
    step();
    valid8 = 1'b0;
    lat = -1; pulses = 0; got = '0;
    for (int c = 0; c < 30; c++) begin
      if (done8) begin
        pulses++;
        lat = c;
        got = bcd8;
      end else if (!ready8) begin
        check($sformatf("%s_hold", name), 32'(bcd8), 32'(last_bcd8));
      end
      if (ready8) break;
      step();
    end
    check($sformatf("%s_bcd", name), 32'(got), 32'(exp));
    check($sformatf("%s_latency", name), lat, 8);
    check($sformatf("%s_pulses", name), pulses, 1);
    last_bcd8 = exp;
  endtask

  initial begin
    vec_t vecs[8];
    logic [15:0] bb_val[5];
    logic [19:0] bb_exp[5];
    int idx, prev, pulses;
    logic [19:0] got;
    logic [15:0] rv;
    logic [7:0]  rv8;

    vecs[0] = '{16'd1234,  20'h01234};
    vecs[1] = '{16'd0,     20'h00000};
    vecs[2] = '{16'd1,     20'h00001};
    vecs[3] = '{16'd9,     20'h00009};
    vecs[4] = '{16'd10,    20'h00010};
    vecs[5] = '{16'd99,    20'h00099};
    vecs[6] = '{16'd100,   20'h00100};
    vecs[7] = '{16'd65535, 20'h65535};

    // Reset and idle behaviour
    step();
    step();
    check("ready_in_reset", 32'(ready), 0);
    check("ready8_in_reset", 32'(ready8), 0);
    rst = 1'b0;
    #1;
    check("ready_after_release", 32'(ready), 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_ready", 32'(ready), 1);
      check("idle_done", 32'(done), 0);
      check("idle_bcd", 32'(bcd), 0);
    end

    // Table vectors
    for (int i = 0; i < 8; i++) begin
      run_conv($sformatf("vec%0d", i), vecs[i].val, vecs[i].exp);
      step();
    end

    // Back-to-back with valid held high
    bb_val = '{16'd0, 16'd9, 16'd10, 16'd255, 16'd65535};
    bb_exp = '{20'h00000, 20'h00009, 20'h00010, 20'h00255, 20'h65535};
    idx = 0; prev = 0;
    sqrt = bb_val[0];
    valid = 1'b1;
    for (int c = 0; c < 200 && idx < 5; c++) begin
      step();
      if (done) begin
        check($sformatf("b2b%0d_bcd", idx), 32'(bcd), 32'(bb_exp[idx]));
        if (idx > 0) check($sformatf("b2b%0d_spacing", idx), c - prev, 18);
        prev = c;
        idx++;
        if (idx < 5) sqrt = bb_val[idx];
        else valid = 1'b0;
      end
    end
    valid = 1'b0;
    check("b2b_count", idx, 5);
    last_bcd = 20'h65535;
    step();
    step();

    // valid during SHIFT and DONE is ignored
    sqrt = 16'd42;
    valid = 1'b1;
    step();
    valid = 1'b0;
    repeat (4) step();
    sqrt = 16'd999;
    valid = 1'b1;
    step();
    pulses = 0; got = '0;
    for (int c = 0; c < 40; c++) begin
      valid = 1'b0;
      if (done) begin
        pulses++;
        got = bcd;
        sqrt = 16'd999;
        valid = 1'b1;
      end
      step();
    end
    valid = 1'b0;
    check("ignore_pulses", pulses, 1);
    check("ignore_bcd", 32'(got), 32'h00042);
    check("ignore_bcd_final", 32'(bcd), 32'h00042);
    check("ignore_ready", 32'(ready), 1);
    last_bcd = 20'h00042;

    // Reset in the 8th SHIFT cycle aborts
    sqrt = 16'd4321;
    valid = 1'b1;
    step();
    valid = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    #1;
    check("abort_ready_in_reset", 32'(ready), 0);
    step();
    rst = 1'b0;
    #1;
    check("abort_done", 32'(done), 0);
    check("abort_bcd", 32'(bcd), 0);
    check("abort_ready", 32'(ready), 1);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (done) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    last_bcd = '0;
    last_bcd8 = '0;
    run_conv("after_abort", 16'd77, 20'h00077);
    step();

    // Reset wins over valid at the same edge
    rst = 1'b1;
    valid = 1'b1;
    sqrt = 16'd5;
    step();
    rst = 1'b0;
    valid = 1'b0;
    #1;
    check("rst_valid_ready", 32'(ready), 1);
    step();
    check("rst_valid_ready_next", 32'(ready), 1);
    check("rst_valid_bcd", 32'(bcd), 0);
    last_bcd = '0;

    // Randomised against the decimal model
    for (int i = 0; i < 16; i++) begin
      rv = 16'($urandom_range(0, 65535));
      run_conv($sformatf("rand%0d_v%0d", i, rv), rv, 20'(ref_bcd(rv, 5)));
      step();
    end

    // Narrow instance WIDTH=8, DIGITS=3
    run_conv8("w8_200", 8'd200, 12'h200);
    step();
    run_conv8("w8_255", 8'd255, 12'h255);
    step();
    for (int i = 0; i < 6; i++) begin
      rv8 = 8'($urandom_range(0, 255));
      run_conv8($sformatf("w8rand%0d_v%0d", i, rv8), rv8, 12'(ref_bcd(rv8, 3)));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
